// File: rtl/fft_pkg.sv
// fft_pkg: frame reader state encoding and default sizing constants shared by the reader and its bench
package fft_pkg;
  typedef enum logic [1:0] {IDLE, ARM, READ, FLUSH} state_t;
  localparam int DATA_WIDTH_DEF = 12;
  localparam int LEVEL_WIDTH_DEF = 12;
  localparam int FRAME_LEN_DEF = 1024;
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry output buffer (clk_i/rst_i, push_i+data_i in, pop_i, data_o/valid_o head, count_o occupancy)
module skid_buf2 #(
  parameter int WIDTH = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);
  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, slot;
  assign slot = cnt_q - {1'b0, pop_i};
  assign e0_d = push_i && slot == 2'd0 ? data_i : pop_i ? e1_q : e0_q;
  assign e1_d = push_i && slot == 2'd1 ? data_i : e1_q;
  assign cnt_d = slot + {1'b0, push_i};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign data_o = e0_q;
  assign valid_o = cnt_q != 2'd0;
  assign count_o = cnt_q;
endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: reads FRAME_LEN-sample frames from an ADC FIFO (rd_* side) and streams them out (m_* side) with frame_cnt/underrun status
module fifo_frame_reader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int SIGNED_OUT = 1
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   enable,
  output logic                   rd_en,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_empty,
  input  logic [LEVEL_WIDTH-1:0] rd_water_level,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [15:0]            frame_cnt,
  output logic                   underrun
);
  localparam logic [LEVEL_WIDTH-1:0] LEN = LEVEL_WIDTH'(FRAME_LEN);
  localparam logic [LEVEL_WIDTH-1:0] LAST = LEVEL_WIDTH'(FRAME_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] FLIP = SIGNED_OUT != 0 ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;
  state_t state_q, state_d;
  logic [LEVEL_WIDTH-1:0] issued_q, issued_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic underrun_q, underrun_d, fly_q, fly_last_q, pop, acc_last, issue_last;
  logic [1:0] buf_cnt;
  logic [DATA_WIDTH:0] buf_out;
  assign pop = m_valid & m_ready;
  assign acc_last = pop & m_last;
  // a word leaving the buffer this cycle frees its slot for a new read
  assign rd_en = !rd_rst && state_q == READ && !rd_empty && issued_q < LEN
              && buf_cnt + {1'b0, fly_q} - {1'b0, pop} < 2'd2;
  assign issue_last = rd_en && issued_q == LAST;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = enable ? ARM : IDLE;
      ARM:     state_d = !enable ? IDLE : rd_water_level >= LEN ? READ : ARM;
      READ:    state_d = issue_last ? FLUSH : READ;
      FLUSH:   state_d = acc_last ? (enable ? ARM : IDLE) : FLUSH;
      default: state_d = IDLE;
    endcase
    issued_d = state_q == READ ? issued_q + LEVEL_WIDTH'(rd_en) : '0;
    frame_cnt_d = frame_cnt_q + 16'(acc_last);
    underrun_d = underrun_q | (state_q == READ && issued_q < LEN && rd_empty);
  end
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= IDLE;
      issued_q <= '0;
      frame_cnt_q <= '0;
      underrun_q <= 1'b0;
      fly_q <= 1'b0;
      fly_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issued_q <= issued_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q <= underrun_d;
      fly_q <= rd_en;
      fly_last_q <= issue_last;
    end
  end
  skid_buf2 #(.WIDTH(DATA_WIDTH + 1)) u_buf (
    .clk_i  (rd_clk),
    .rst_i  (rd_rst),
    .push_i (fly_q),
    .pop_i  (pop),
    .data_i ({fly_last_q, rd_data ^ FLIP}),
    .data_o (buf_out),
    .valid_o(m_valid),
    .count_o(buf_cnt)
  );
  assign m_data = buf_out[DATA_WIDTH-1:0];
  assign m_last = m_valid & buf_out[DATA_WIDTH];
  assign frame_cnt = frame_cnt_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: randomized FIFO/sink model with scoreboard for fifo_frame_reader
module tb_fifo_frame_reader;
  import fft_pkg::*;
  localparam int DW = 12, LW = 12, FL = 1024;
  logic rd_clk = 0, rd_rst = 1, enable = 0, rd_en, rd_empty = 1, m_valid, m_ready = 0, m_last, underrun;
  logic [DW-1:0] rd_data = '0, m_data;
  logic [LW-1:0] rd_water_level = '0;
  logic [15:0] frame_cnt;
  always #5 rd_clk = ~rd_clk;
  fifo_frame_reader #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .FRAME_LEN(FL), .SIGNED_OUT(1)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_water_level(rd_water_level), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .frame_cnt(frame_cnt), .underrun(underrun)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  int fifo_q[$], exp_q[$], got_q[$];
  int pend = -1, force_cnt = 0, mode = 0, beats = 0, frames = 0, exp_frames = 0;
  int outstanding = 0, cyc_n = 0, first_rd = -1, first_v = -1, last_cyc = -1;
  bit hold = 0;
  logic [DW-1:0] hold_data;
  logic hold_last;
  function automatic int conv(int w);
    return (w ^ 'h800) & 'hFFF;
  endfunction
  task automatic cyc();
    @(negedge rd_clk);
    cyc_n++;
    if (rd_empty) chk("rd_en_when_empty", rd_en, 0);
    if (rd_rst) begin
      chk("rd_en_in_reset", rd_en, 0);
      exp_q.delete();
      outstanding = 0; beats = 0; exp_frames = 0; hold = 0; pend = -1;
    end else begin
      chk("frame_cnt", frame_cnt, exp_frames);
      if (hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_data);
        chk("hold_last", m_last, hold_last);
      end
      pend = -1;
      if (rd_en) begin
        if (fifo_q.size() == 0) chk("read_past_fifo", 1, 0);
        else begin
          pend = fifo_q.pop_front();
          exp_q.push_back(conv(pend));
          outstanding++;
          if (first_rd < 0) first_rd = cyc_n;
        end
      end
      if (m_valid && first_v < 0) first_v = cyc_n;
      if (m_valid && m_ready) begin
        got_q.push_back(int'(m_data));
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else chk("m_data", m_data, exp_q.pop_front());
        chk("m_last", m_last, beats == FL - 1);
        outstanding--;
        beats++;
        if (beats == FL) begin
          beats = 0;
          exp_frames = (exp_frames + 1) & 'hFFFF;
          frames++;
          last_cyc = cyc_n;
        end
      end
      chk("unaccepted_le_2", outstanding <= 2, 1);
      hold = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
    end
    @(posedge rd_clk);
    #1;
    if (pend >= 0) rd_data = DW'(pend);
    m_ready = mode == 0 ? 1'b1 : mode == 1 ? !m_ready : ($urandom_range(0, 3) != 0);
    rd_empty = force_cnt > 0 || fifo_q.size() == 0;
    if (force_cnt > 0) force_cnt--;
    rd_water_level = LW'(fifo_q.size());
  endtask
  task automatic load(int n, bit desc);
    for (int i = 0; i < n; i++) fifo_q.push_back(desc ? 'hFFF - i : int'($urandom_range(0, 4095)));
  endtask
  task automatic wait_frames(int target, int budget);
    int k = 0;
    while (frames < target && k < budget) begin cyc(); k++; end
    if (frames < target) chk("frame_timeout", frames, target);
  endtask
  task automatic wait_beats(int n, int budget);
    int k = 0;
    while (beats < n && k < budget) begin cyc(); k++; end
    if (beats < n) chk("beat_timeout", beats, n);
  endtask
  task automatic check_reset_state();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_state", dut.state_q, IDLE);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    repeat (3) cyc();
    rd_rst = 0;
    check_reset_state();
    load(FL - 1, 0);
    enable = 1;
    repeat (20) begin cyc(); chk("rd_en_below_level", rd_en, 0); end
    chk("state_arm", dut.state_q, ARM);
    first_rd = -1; first_v = -1;
    load(1, 0);
    wait_frames(1, 3000);
    chk("first_valid_latency", first_v - first_rd, 2);
    chk("consecutive_beats", last_cyc - first_v, FL - 1);
    chk("frame_cnt_1", frame_cnt, 1);
    chk("underrun_clean", underrun, 0);
    mode = 1;
    got_q.delete();
    load(FL, 1);
    wait_frames(2, 5000);
    chk("frame_cnt_2", frame_cnt, 2);
    if (got_q.size() < 2) chk("toggle_beats", got_q.size(), 2);
    else begin
      chk("toggle_first", got_q[0], 'h7FF);
      chk("toggle_second", got_q[1], 'h7FE);
    end
    mode = 0;
    load(FL, 0);
    wait_beats(300, 3000);
    force_cnt = 5;
    wait_frames(3, 3000);
    chk("underrun_set", underrun, 1);
    chk("frame_cnt_3", frame_cnt, 3);
    mode = 2;
    got_q.delete();
    fifo_q.push_back('h800);
    fifo_q.push_back('hFFF);
    load(FL - 2, 0);
    k = 0;
    while (frames < 4 && k < 8000) begin
      if ($urandom_range(0, 63) == 0 && force_cnt == 0) force_cnt = $urandom_range(1, 4);
      if (beats == 100) enable = 0;
      cyc();
      k++;
    end
    if (frames < 4) chk("frame_timeout", frames, 4);
    chk("state_idle_after_disable", dut.state_q, IDLE);
    chk("frame_cnt_4", frame_cnt, 4);
    if (got_q.size() < 2) chk("signed_beats", got_q.size(), 2);
    else begin
      chk("signed_800", got_q[0], 'h000);
      chk("signed_fff", got_q[1], 'h7FF);
    end
    enable = 1;
    mode = 0;
    load(FL, 0);
    wait_beats(500, 3000);
    rd_rst = 1;
    cyc();
    rd_rst = 0;
    check_reset_state();
    fifo_q.delete();
    load(FL, 0);
    wait_frames(frames + 1, 3000);
    chk("frame_cnt_after_reset", frame_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: sample width, matching the ADC FIFO read width.
REQ-002 SHALL have parameter LEVEL_WIDTH, default 12: FIFO read water-level width (depth-width + 1).
REQ-003 SHALL have parameter FRAME_LEN, default 1024: samples per output frame, range 2 .. 2**(LEVEL_WIDTH-1).
REQ-004 SHALL have parameter SIGNED_OUT, default 1: when 1, invert the sample MSB (offset-binary to two's complement).
REQ-005 SHALL use one clock and a synchronous, active-high reset: rd_clk  in  1  sole clock; rd_rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have port enable  in  1  frame capture permitted.
REQ-007 SHALL have port rd_en  out  1  FIFO read strobe.
REQ-008 SHALL have port rd_data  in  DATA_WIDTH  FIFO data, valid the cycle after rd_en.
REQ-009 SHALL have port rd_empty  in  1  FIFO empty.
REQ-010 SHALL have port rd_water_level  in  LEVEL_WIDTH  FIFO occupancy.
REQ-011 SHALL have port m_data  out  DATA_WIDTH  output sample.
REQ-012 SHALL have port m_valid  out  1  m_data valid.
REQ-013 SHALL have port m_ready  in  1  downstream accepts.
REQ-014 SHALL have port m_last  out  1  last sample of frame, qualified by m_valid.
REQ-015 SHALL have port frame_cnt  out  16  completed frames, wraps modulo 2**16.
REQ-016 SHALL have port underrun  out  1  sticky: FIFO empty while frame reads were outstanding.

Function
REQ-017 SHALL implement states IDLE, ARM, READ, FLUSH.
REQ-018 IDLE -> ARM when enable=1.
REQ-019 ARM -> READ when rd_water_level >= FRAME_LEN; ARM -> IDLE when enable=0.
REQ-020 READ -> FLUSH on the cycle the FRAME_LEN-th rd_en is issued.
REQ-021 FLUSH -> ARM (enable=1) or IDLE (enable=0) in the cycle after the m_last beat is accepted (m_valid & m_ready & m_last).
REQ-022 SHALL contain a 2-entry output buffer; occupancy = buffered words + reads in flight.
REQ-023 SHALL drive rd_en = READ & !rd_empty & issued<FRAME_LEN & occupancy<2, where occupancy counts a word popped by m_valid & m_ready in the same cycle as freed.
REQ-024 SHALL never assert rd_en when rd_empty=1.
REQ-025 SHALL capture rd_data into the buffer the cycle after rd_en; the word is presented on m_data/m_valid one cycle later.
REQ-026 First-sample latency: ARM->READ at edge t, rd_en high in cycle t, m_valid high from cycle t+2.
REQ-027 SHALL sustain one sample per cycle while m_ready=1 and the FIFO is non-empty.
REQ-028 m_data/m_valid/m_last SHALL hold stable while m_valid=1 and m_ready=0; no sample is lost or duplicated.
REQ-029 m_last SHALL assert only on the FRAME_LEN-th sample of a frame.
REQ-030 frame_cnt SHALL increment on each accepted m_last beat, wrapping 0xFFFF -> 0x0000.
REQ-031 underrun SHALL set when state=READ, issued<FRAME_LEN and rd_empty=1; the reader SHALL stall and resume without dropping a sample.
REQ-032 enable deassertion during READ/FLUSH SHALL complete the current frame, then enter IDLE.
REQ-033 SHALL apply the SIGNED_OUT MSB inversion at buffer capture, not on the output path.

Reset
REQ-034 rd_rst=1 SHALL force state IDLE, buffer empty, issued=0, m_valid=0, m_last=0, m_data=0, frame_cnt=0, underrun=0.
REQ-035 rd_en SHALL be 0 in any cycle with rd_rst=1, including reset mid-frame; a partial frame is discarded.

Structure
REQ-036 The state encoding and frame-length constants SHALL live in the shared package fft_pkg.
REQ-037 The 2-entry buffer SHALL be a sub-module named skid_buf2 (DATA_WIDTH+1 bits wide, carrying data and last).

Verification
REQ-038 FIFO model with level 1024, m_ready=1 -> 1024 consecutive m_valid beats, m_last on beat 1024, frame_cnt=1.
REQ-039 Level 1023 held -> rd_en stays 0, state ARM; level steps to 1024 -> first m_valid two cycles after rd_en.
REQ-040 m_ready toggled 1/0 every cycle -> data sequence 0xFFF, 0xFFE, ... matches the written order exactly; rd_en never leaves more than 2 words unaccepted.
REQ-041 rd_empty forced to 1 for 5 cycles mid-frame -> underrun=1, rd_en=0 for those cycles, frame still totals 1024 beats.
REQ-042 rd_rst pulsed at beat 500 -> next cycle all outputs 0, state IDLE; a new full frame follows after reset is released.
REQ-043 SIGNED_OUT=1, FIFO word 0x800 -> m_data 0x000; word 0xFFF -> 0x7FF.
